// File: rtl/mips_fetch.sv
// Instruction fetch stage: PC register, req/ack instruction-memory handshake,
// and the instruction register feeding the control decoder.
module mips_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_data_in,
  input  logic        consume_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [5:0]  op_out,
  output logic [5:0]  func_out,
  output logic [31:0] instr_pc_out,
  output logic [31:0] pc_plus4_out
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_INIT = RESET_PC & ~XLEN'(3);
  localparam logic [XLEN-1:0] WORD    = XLEN'(4);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_DROP = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redir_q, redir_d;
  logic [XLEN-1:0] instr_q, instr_pc_q;
  logic            valid_q;
  logic            req_c, ack_c, load_c, clear_c;
  logic [XLEN-1:0] target_c;

  assign target_c = redirect_pc_in & ~XLEN'(3);
  assign ack_c    = imem_ack_in & req_c;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_REQ;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        if (ack_c)            state_d = redirect_in ? S_REQ : S_HOLD;
        else if (redirect_in) state_d = S_DROP;
      end
      S_DROP: if (ack_c) state_d = S_REQ;
      S_HOLD: if (redirect_in || consume_in) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  // Request decode plus the PC / redirect-target / instruction-register controls.
  always_comb begin
    req_c   = (state_q != S_HOLD) && !reset;
    load_c  = 1'b0;
    clear_c = 1'b0;
    pc_d    = pc_q;
    redir_d = redir_q;
    case (state_q)
      S_REQ: begin
        if (ack_c && redirect_in) begin
          pc_d = target_c;
        end else if (ack_c) begin
          load_c = 1'b1;
          pc_d   = pc_q + WORD;
        end else if (redirect_in) begin
          redir_d = target_c;
        end
      end
      S_DROP: begin
        // The most recent redirect wins, even one arriving with the ack.
        if (ack_c)            pc_d    = redirect_in ? target_c : redir_q;
        else if (redirect_in) redir_d = target_c;
      end
      S_HOLD: begin
        if (redirect_in) begin
          pc_d    = target_c;
          clear_c = 1'b1;
        end else if (consume_in) begin
          clear_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= PC_INIT;
      redir_q    <= PC_INIT;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      instr_pc_q <= PC_INIT;
    end else begin
      pc_q    <= pc_d;
      redir_q <= redir_d;
      if (load_c) begin
        instr_q    <= imem_data_in;
        valid_q    <= 1'b1;
        instr_pc_q <= pc_q;
      end else if (clear_c) begin
        instr_q    <= '0;
        valid_q    <= 1'b0;
        instr_pc_q <= pc_q;
      end
    end
  end

  assign imem_req_out    = req_c;
  assign imem_addr_out   = pc_q;
  assign instr_valid_out = valid_q;
  assign instr_out       = instr_q;
  assign op_out          = instr_q[31:26];
  assign func_out        = instr_q[5:0];
  assign instr_pc_out    = instr_pc_q;
  assign pc_plus4_out    = instr_pc_q + WORD;

endmodule

// File: tb/tb_mips_fetch.sv
// Bench for mips_fetch: cycle vectors, a scoreboarded sequential stream,
// and a wrap-around check on a second instance reset near the top of memory.
module tb_mips_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ack, consume, redirect;
  logic [31:0] data, rpc;
  logic        req, valid;
  logic [31:0] addr, instr, ipc, pc4;
  logic [5:0]  op, func;

  logic        w_reset, w_ack, w_consume, w_redirect;
  logic [31:0] w_data, w_rpc;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_ipc, w_pc4;
  logic [5:0]  w_op, w_func;

  mips_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req_out(req), .imem_addr_out(addr),
    .imem_ack_in(ack), .imem_data_in(data),
    .consume_in(consume), .redirect_in(redirect), .redirect_pc_in(rpc),
    .instr_valid_out(valid), .instr_out(instr), .op_out(op), .func_out(func),
    .instr_pc_out(ipc), .pc_plus4_out(pc4)
  );

  mips_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(w_reset),
    .imem_req_out(w_req), .imem_addr_out(w_addr),
    .imem_ack_in(w_ack), .imem_data_in(w_data),
    .consume_in(w_consume), .redirect_in(w_redirect), .redirect_pc_in(w_rpc),
    .instr_valid_out(w_valid), .instr_out(w_instr), .op_out(w_op), .func_out(w_func),
    .instr_pc_out(w_ipc), .pc_plus4_out(w_pc4)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst, ack;
    logic [31:0] data;
    logic        cons, redir;
    logic [31:0] rpc;
    logic        chk_pre, exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr, exp_ipc;
  } vec_t;

  typedef struct {
    logic [31:0] pc, data;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic a, input logic [31:0] d,
                              input logic c, input logic rd, input logic [31:0] t,
                              input logic cp, input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ei, input logic [31:0] eipc);
    vec_t v;
    v.rst = r; v.ack = a; v.data = d; v.cons = c; v.redir = rd; v.rpc = t;
    v.chk_pre = cp; v.exp_req = er; v.exp_addr = ea;
    v.exp_valid = ev; v.exp_instr = ei; v.exp_ipc = eipc;
    return v;
  endfunction

  task automatic apply(input int idx, input vec_t v);
    logic [31:0] ei;
    reset = v.rst; ack = v.ack; data = v.data;
    consume = v.cons; redirect = v.redir; rpc = v.rpc;
    #1;
    if (v.chk_pre) begin
      chk($sformatf("v%0d_req", idx), 32'(req), 32'(v.exp_req));
      if (v.exp_req) chk($sformatf("v%0d_addr", idx), addr, v.exp_addr);
    end
    @(posedge clk);
    #1;
    ei = v.exp_instr;
    chk($sformatf("v%0d_valid", idx), 32'(valid), 32'(v.exp_valid));
    chk($sformatf("v%0d_instr", idx), instr, ei);
    chk($sformatf("v%0d_op", idx), 32'(op), 32'(ei[31:26]));
    chk($sformatf("v%0d_func", idx), 32'(func), 32'(ei[5:0]));
    chk($sformatf("v%0d_ipc", idx), ipc, v.exp_ipc);
    chk($sformatf("v%0d_pc4", idx), pc4, v.exp_ipc + 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_addr;
    logic [31:0] d;
    sb_t e;

    reset = 1'b1; ack = 1'b0; data = '0; consume = 1'b0; redirect = 1'b0; rpc = '0;
    w_reset = 1'b1; w_ack = 1'b0; w_data = '0; w_consume = 1'b0; w_redirect = 1'b0; w_rpc = '0;

    //           rst ack data           con rd  rpc            cp er addr           v  instr          ipc
    vecs.push_back(mk(1, 0, 32'h0,          0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,          32'h0));
    vecs.push_back(mk(1, 0, 32'h0,          0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,          32'h0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 0, 32'h0,         1, 1, 32'h0,         0, 32'h0,          32'h0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 0, 32'h0,         1, 1, 32'h0,         0, 32'h0,          32'h0));
    vecs.push_back(mk(0, 1, 32'h2008_0005,  0, 0, 32'h0,         1, 1, 32'h0,         1, 32'h2008_0005,  32'h0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h2008_0005,  32'h0));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFF,  0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h2008_0005,  32'h0));
    vecs.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,          32'h4));
    vecs.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,         1, 1, 32'h4,         0, 32'h0,          32'h4));
    vecs.push_back(mk(0, 1, 32'h0109_5020,  0, 0, 32'h0,         1, 1, 32'h4,         1, 32'h0109_5020,  32'h4));
    vecs.push_back(mk(0, 0, 32'h0,          1, 1, 32'h0000_0043, 1, 0, 32'h0,         0, 32'h0,          32'h8));
    vecs.push_back(mk(0, 0, 32'h0,          0, 0, 32'h0,         1, 1, 32'h40,        0, 32'h0,          32'h8));
    vecs.push_back(mk(0, 0, 32'h0,          0, 1, 32'h80,        1, 1, 32'h40,        0, 32'h0,          32'h8));
    vecs.push_back(mk(0, 0, 32'h0,          0, 0, 32'h0,         1, 1, 32'h40,        0, 32'h0,          32'h8));
    vecs.push_back(mk(0, 1, 32'hDEAD_BEEF,  0, 0, 32'h0,         1, 1, 32'h40,        0, 32'h0,          32'h8));
    vecs.push_back(mk(0, 0, 32'h0,          0, 0, 32'h0,         1, 1, 32'h80,        0, 32'h0,          32'h8));
    vecs.push_back(mk(0, 1, 32'h1234_5678,  0, 1, 32'h100,       1, 1, 32'h80,        0, 32'h0,          32'h8));
    vecs.push_back(mk(0, 0, 32'h0,          0, 0, 32'h0,         1, 1, 32'h100,       0, 32'h0,          32'h8));
    vecs.push_back(mk(0, 0, 32'h0,          0, 1, 32'h200,       1, 1, 32'h100,       0, 32'h0,          32'h8));
    vecs.push_back(mk(0, 0, 32'h0,          0, 1, 32'h307,       1, 1, 32'h100,       0, 32'h0,          32'h8));
    vecs.push_back(mk(0, 1, 32'h5555_AAAA,  0, 0, 32'h0,         1, 1, 32'h100,       0, 32'h0,          32'h8));
    vecs.push_back(mk(0, 0, 32'h0,          0, 0, 32'h0,         1, 1, 32'h304,       0, 32'h0,          32'h8));
    vecs.push_back(mk(0, 0, 32'h0,          0, 1, 32'h400,       1, 1, 32'h304,       0, 32'h0,          32'h8));
    vecs.push_back(mk(1, 1, 32'hABCD_0001,  0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,          32'h0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 0, 32'h0,         1, 1, 32'h0,         0, 32'h0,          32'h0));
    vecs.push_back(mk(0, 1, 32'h8C22_0004,  0, 0, 32'h0,         1, 1, 32'h0,         1, 32'h8C22_0004,  32'h0));

    foreach (vecs[i]) apply(i, vecs[i]);

    // Sequential stream: zero-wait memory, consume every held instruction.
    ack = 1'b0; redirect = 1'b0; consume = 1'b1;
    tick();
    consume = 1'b0;
    exp_addr = 32'h4;
    chk("stream_clear_valid", 32'(valid), 32'h0);
    chk("stream_clear_ipc", ipc, exp_addr);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("s%0d_req", k), 32'(req), 32'h1);
      chk($sformatf("s%0d_addr", k), addr, exp_addr);
      d = 32'h0109_5020 | (exp_addr << 16);
      e.pc = exp_addr; e.data = d;
      sbq.push_back(e);
      ack = 1'b1; data = d;
      tick();
      ack = 1'b0;
      if (!valid) begin
        checks++; errors++;
        $display("FAIL s%0d_valid actual=0 expected=1", k);
      end else if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL s%0d_sb actual=empty expected=entry", k);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("s%0d_instr", k), instr, e.data);
        chk($sformatf("s%0d_ipc", k), ipc, e.pc);
        chk($sformatf("s%0d_pc4", k), pc4, e.pc + 32'd4);
        chk($sformatf("s%0d_func", k), 32'(func), 32'h20);
      end
      exp_addr = exp_addr + 32'd4;
      consume = 1'b1;
      tick();
      consume = 1'b0;
      chk($sformatf("s%0d_valid_low", k), 32'(valid), 32'h0);
    end
    chk("stream_sb_empty", 32'(sbq.size()), 32'h0);

    // Wrap-around from the top word of the address space.
    reset = 1'b1;
    w_reset = 1'b0;
    #1;
    chk("w_req", 32'(w_req), 32'h1);
    chk("w_addr", w_addr, 32'hFFFF_FFFC);
    chk("w_reset_ipc", w_ipc, 32'hFFFF_FFFC);
    chk("w_reset_pc4", w_pc4, 32'h0);
    w_ack = 1'b1; w_data = 32'h2400_0001;
    tick();
    w_ack = 1'b0;
    chk("w_valid", 32'(w_valid), 32'h1);
    chk("w_instr", w_instr, 32'h2400_0001);
    chk("w_op", 32'(w_op), 32'h09);
    chk("w_func", 32'(w_func), 32'h01);
    chk("w_ipc", w_ipc, 32'hFFFF_FFFC);
    chk("w_pc4", w_pc4, 32'h0);
    w_consume = 1'b1;
    tick();
    w_consume = 1'b0;
    chk("w_next_req", 32'(w_req), 32'h1);
    chk("w_next_addr", w_addr, 32'h0);
    chk("w_next_valid", 32'(w_valid), 32'h0);
    chk("w_next_ipc", w_ipc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_fetch.md
# mips_fetch

Instruction fetch stage for the MIPS datapath. Holds the program counter, issues word requests to instruction memory over a req/ack handshake, and captures the returned instruction in an instruction register. The register's opcode and function fields drive the control decoder's `op_in`/`func_in`. Branch and jump redirects from the datapath reload the PC; a fetch that is already in flight when a redirect arrives is discarded.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `imem_req_out`  out  1: fetch request to instruction memory.
- `imem_addr_out`  out  32: word address of the request (byte address, bits [1:0]=00).
- `imem_ack_in`  in  1: one-cycle pulse; `imem_data_in` is valid in the same cycle.
- `imem_data_in`  in  32: instruction word.
- `consume_in`  in  1: datapath has executed the held instruction.
- `redirect_in`  in  1: taken branch or jump; one-cycle pulse.
- `redirect_pc_in`  in  32: target PC; bits [1:0] ignored (forced to 00).
- `instr_valid_out`  out  1: `instr_out` holds a live instruction.
- `instr_out`  out  32: instruction register.
- `op_out`  out  6: `instr_out[31:26]`, to the control decoder's `op_in`.
- `func_out`  out  6: `instr_out[5:0]`, to the control decoder's `func_in`.
- `instr_pc_out`  out  32: PC of the held instruction.
- `pc_plus4_out`  out  32: `instr_pc_out + 4`, used for branch target computation.

## Operation
- Internal PC register `pc_q`; `imem_addr_out = pc_q` whenever `imem_req_out` is 1.
- FSM states: REQ, DROP, HOLD.
- **REQ.** `imem_req_out` = 1.
  - On `imem_ack_in`:
    - load `instr_out` ← `imem_data_in`;
    - `instr_pc_out` ← `pc_q`;
    - `pc_q` ← `pc_q + 4`;
    - `instr_valid_out` ← 1;
    - go to HOLD.
  - On `redirect_in` without ack: latch the target into `redir_q`; go to DROP.
  - On `redirect_in` and ack in the same cycle: discard the data; `pc_q` ← target; stay in REQ.
- **DROP.** `imem_req_out` = 1 and `imem_addr_out` is unchanged (the address must stay stable until ack).
  - On ack: discard the data; `pc_q` ← `redir_q`; go to REQ.
  - A further redirect in DROP overwrites `redir_q`; the last redirect wins.
- **HOLD.** `imem_req_out` = 0; `instr_valid_out` = 1.
  - On `redirect_in`: `pc_q` ← target; clear the instruction register; go to REQ. Redirect has priority over `consume_in`.
  - Else on `consume_in`: clear the instruction register; go to REQ.
  - Otherwise hold all outputs.
- **Clearing the instruction register.**
  - `instr_out` ← 0, `instr_valid_out` ← 0, `instr_pc_out` ← `pc_q`.
  - `op_out`/`func_out` then read 0/0, which the decoder treats as a nop.
- `consume_in` outside HOLD is ignored.
- `imem_ack_in` while `imem_req_out` = 0 is ignored.
- **Arithmetic.**
  - 32-bit, modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
  - `pc_plus4_out` wraps the same way.

## Timing
- **Reset values:**
  - state = REQ; `pc_q` = `RESET_PC`;
  - `imem_req_out` = 0 during the reset cycle only;
  - `instr_valid_out` = 0; `instr_out` = 0; `op_out` = 0; `func_out` = 0;
  - `instr_pc_out` = `RESET_PC`; `pc_plus4_out` = `RESET_PC + 4`.
- **First request:** `imem_req_out` rises in the first cycle with `reset` low (combinational from state, masked by reset).
- **Fetch latency:**
  - Request in cycle N, ack earliest in cycle N (zero-wait memory allowed).
  - `instr_valid_out` = 1 from cycle ack+1.
- **After consume:** `consume_in` in cycle M → `instr_valid_out` = 0 and `imem_req_out` = 1 in cycle M+1, at address (held PC + 4).
- **After redirect in HOLD:** `redirect_in` in cycle M → request to the target in cycle M+1.
- **After redirect in REQ/DROP:** the in-flight ack is swallowed; the target request starts the cycle after that ack.
- **Reset mid-operation:** reset overrides everything in the same edge, including a simultaneous ack or redirect. Outstanding memory data arriving after reset is ignored, because `imem_ack_in` is ignored unless `imem_req_out` = 1. Memory must drop any in-flight request on reset.
- **Latch rule:** all outputs are registered except `imem_req_out`/`imem_addr_out` (decoded from state and `pc_q`) and `op_out`/`func_out`/`pc_plus4_out` (slices or adder of registers).

## Test plan
- **Reset and first fetch.** `RESET_PC`=0; hold reset 2 cycles, release.
  - Expect `imem_req_out`=1, `imem_addr_out`=0 in the first cycle with reset low.
  - Ack with 32'h2008_0005 after 2 cycles → `instr_valid_out`=1, `op_out`=6'h08, `instr_pc_out`=0, `pc_plus4_out`=4.
- **Sequential stream.** Zero-wait ack; assert `consume_in` in each HOLD cycle.
  - Expect addresses 0, 4, 8, 12 on successive requests.
  - Expect `instr_valid_out` to alternate 1/0.
  - Expect `func_out`=6'h20 for data 32'h0109_5020.
- **Redirect in HOLD.** Assert `redirect_in` (target 32'h0000_0043) and `consume_in` together.
  - Next request address = 32'h0000_0040.
  - `instr_valid_out`=0, `op_out`=0.
- **Redirect during in-flight fetch.** Request at 0x10; `redirect_in` to 0x80 one cycle before a 3-cycle ack.
  - Address stays 0x10 until ack.
  - Ack data is discarded (`instr_valid_out` stays 0).
  - Next request is 0x80.
  - Repeat with the redirect coincident with the ack → same result.
- **Wrap-around.** `RESET_PC`=32'hFFFF_FFFC; fetch, consume.
  - `pc_plus4_out`=0; next request address=0.
- **Reset mid-request.** Assert reset while in DROP with ack arriving in the same cycle.
  - Next cycle: all outputs at reset values, data not loaded.
  - First post-reset request at `RESET_PC`.
